// File: rtl/soc_uart_tx_if.sv
// Write-port and status bundle between the SoC core and the UART transmitter.
// The core drives WR/WDATA/CLR; the transmitter returns the status fields.
interface soc_uart_tx_if #(
  parameter int FIFO_AW = 4
);
  logic               WR;
  logic [7:0]         WDATA;
  logic               CLR;
  logic               READY;
  logic               BUSY;
  logic [FIFO_AW:0]   LEVEL;
  logic               OVF;

  modport master (
    output WR, WDATA, CLR,
    input  READY, BUSY, LEVEL, OVF
  );

  modport slave (
    input  WR, WDATA, CLR,
    output READY, BUSY, LEVEL, OVF
  );
endinterface

// File: rtl/soc_uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO fed by the core's write port,
// drained by a baud-rate FSM that serialises each byte onto TXD.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line high, waiting for the FIFO to become non-empty
// S_START | start bit (low) for BAUD_DIV cycles
// S_DATA  | data bits, LSB first, BAUD_DIV cycles each
// S_STOP  | stop bit (high); pops next byte without gap if available
module soc_uart_tx #(
  parameter int BAUD_DIV = 2170,
  parameter int FIFO_AW  = 4
) (
  input  logic            XCLK,
  input  logic            XRES,
  soc_uart_tx_if.slave    bus,
  output logic            TXD
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(BAUD_DIV - 1);
  localparam logic [FIFO_AW:0] FULL     = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d;
  logic               pop;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               ready_q, ovf_q;
  logic               push, drop, not_empty, tick;

  // READY is registered from the previous level, so a full FIFO refuses a
  // write even when the FSM pops in the same cycle.
  assign push      = bus.WR & ready_q;
  assign drop      = bus.WR & ~ready_q;
  assign not_empty = (level_q != '0);
  assign tick      = (cnt_q == '0);

  // Occupancy after this cycle's push/pop
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage; contents are don't-care after reset since pointers clear
  always_ff @(posedge XCLK) begin
    if (push) mem[wptr_q] <= bus.WDATA;
  end

  // FIFO pointers, level, registered READY and sticky overflow flag
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ready_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + FIFO_AW'(1);
      if (pop)  rptr_q <= rptr_q + FIFO_AW'(1);
      level_q <= level_d;
      ready_q <= (level_d != FULL);
      if (drop)         ovf_q <= 1'b1;
      else if (bus.CLR) ovf_q <= 1'b0;
    end
  end

  // FSM state, baud counter, shifter and registered line output
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  // Next-state, next line value and FIFO pop request
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? CNT_LOAD : cnt_q - CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        cnt_d = CNT_LOAD;
        if (not_empty) begin
          pop     = 1'b1;
          shift_d = mem[rptr_q];
          state_d = S_START;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            txd_d   = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (not_empty) begin
            pop     = 1'b1;
            shift_d = mem[rptr_q];
            state_d = S_START;
            txd_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  assign bus.READY = ready_q;
  assign bus.LEVEL = level_q;
  assign bus.OVF   = ovf_q;
  assign bus.BUSY  = (state_q != S_IDLE) | not_empty;
  assign TXD       = txd_q;

endmodule
